// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding, default polynomial/word size
// (common with the generator) and a saturating 32-bit adder.
package prbs_pkg;

   localparam int PRBS_POLY_LENGTH = 23;
   localparam int PRBS_POLY_TAP    = 18;
   localparam int PRBS_WIDTH       = 17;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } prbs_state_e;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/prbs_popcount.sv
// Combinational population count of a WIDTH-bit vector; zero latency.
module prbs_popcount #(
   parameter int WIDTH = 17
) (
   input  logic [WIDTH-1:0]             bits_i,
   output logic [$clog2(WIDTH+1)-1:0]   count_o
);

   localparam int CW = $clog2(WIDTH+1);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count_o = count_o + CW'(bits_i[i]);
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// PRBS word checker: self-synchronising hunt, free-running LFSR once locked.
// Per-word error flag/count registered one cycle after en; err_cnt saturates.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int POLY_LENGTH  = PRBS_POLY_LENGTH,
   parameter int POLY_TAP     = PRBS_POLY_TAP,
   parameter int WIDTH        = PRBS_WIDTH,
   parameter int LOCK_WORDS   = 4,
   parameter int UNLOCK_WORDS = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [WIDTH-1:0]             data,
   input  logic                         clr,
   output logic                         locked,
   output logic                         word_err,
   output logic [$clog2(WIDTH+1)-1:0]   word_err_bits,
   output logic [31:0]                  err_cnt
);

   localparam int CW  = $clog2(WIDTH+1);
   localparam int LCW = $clog2(LOCK_WORDS+1);
   localparam int UCW = $clog2(UNLOCK_WORDS+1);

   prbs_state_e            state_q, state_d;
   logic [POLY_LENGTH-1:0] hist_q, hist_d;
   logic [POLY_LENGTH-1:0] lfsr_q, lfsr_d;
   logic [LCW-1:0]         clean_q, clean_d;
   logic [UCW-1:0]         bad_q, bad_d;
   logic                   word_err_q, word_err_d;
   logic [CW-1:0]          err_bits_q, err_bits_d;
   logic [31:0]            err_cnt_q, err_cnt_d;

   logic [POLY_LENGTH-1:0] shift_v;
   logic [POLY_LENGTH-1:0] hist_v;
   logic [WIDTH-1:0]       err_v;
   logic                   rx_b;
   logic                   exp_b;
   logic [CW-1:0]          pop_w;

   // Bit-serial prediction unrolled across the word, earliest bit (MSB) first.
   // hist/shift bit 0 holds the most recent bit of the stream.
   always_comb begin
      shift_v = (state_q == LOCKED) ? lfsr_q : hist_q;
      hist_v  = hist_q;
      err_v   = '0;
      rx_b    = 1'b0;
      exp_b   = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         rx_b  = data[WIDTH-1-k];
         exp_b = shift_v[POLY_TAP-1] ^ shift_v[POLY_LENGTH-1];
         err_v[WIDTH-1-k] = rx_b ^ exp_b;
         shift_v = {shift_v[POLY_LENGTH-2:0], (state_q == LOCKED) ? exp_b : rx_b};
         hist_v  = {hist_v[POLY_LENGTH-2:0], rx_b};
      end
   end

   prbs_popcount #(.WIDTH(WIDTH)) u_popcount (
      .bits_i  (err_v),
      .count_o (pop_w)
   );

   always_comb begin
      state_d    = state_q;
      hist_d     = hist_q;
      lfsr_d     = lfsr_q;
      clean_d    = clean_q;
      bad_d      = bad_q;
      word_err_d = word_err_q;
      err_bits_d = err_bits_q;
      err_cnt_d  = clr ? 32'd0 : err_cnt_q;
      if (en) begin
         hist_d     = hist_v;
         word_err_d = |err_v;
         err_bits_d = pop_w;
         case (state_q)
            HUNT: begin
               if (pop_w == '0) begin
                  if (clean_q == LCW'(LOCK_WORDS - 1)) begin
                     state_d = LOCKED;
                     clean_d = '0;
                     lfsr_d  = hist_v;
                  end else begin
                     clean_d = clean_q + LCW'(1);
                  end
               end else begin
                  clean_d = '0;
               end
            end
            LOCKED: begin
               lfsr_d    = shift_v;
               // clr only discards the old total; this word's errors still count
               err_cnt_d = sat_add32(clr ? 32'd0 : err_cnt_q, 32'(pop_w));
               if (pop_w != '0) begin
                  if (bad_q == UCW'(UNLOCK_WORDS - 1)) begin
                     state_d = HUNT;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_q + UCW'(1);
                  end
               end else begin
                  bad_d = '0;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= HUNT;
         hist_q     <= '0;
         lfsr_q     <= '0;
         clean_q    <= '0;
         bad_q      <= '0;
         word_err_q <= 1'b0;
         err_bits_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         hist_q     <= hist_d;
         lfsr_q     <= lfsr_d;
         clean_q    <= clean_d;
         bad_q      <= bad_d;
         word_err_q <= word_err_d;
         err_bits_q <= err_bits_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign locked        = (state_q == LOCKED);
   assign word_err      = word_err_q;
   assign word_err_bits = err_bits_q;
   assign err_cnt       = err_cnt_q;

endmodule
